// File: rtl/apb_slave_mem_pkg.sv
// Shared definitions for the APB completer: FSM encoding, default widths
// and the wait-state counter limits.
package apb_pkg;

  localparam int APB_DATA_WD = 4;
  localparam int APB_ADDR_WD = 4;

  // The wait-state counter is 4 bits wide, so at most 15 wait states.
  localparam int CNT_WD   = 4;
  localparam int MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB3 bus bundle between the initiator (master) and this completer (slave).
interface apb_slave_mem_if
  import apb_pkg::*;
#(
  parameter int ADDR_WD = APB_ADDR_WD,
  parameter int DATA_WD = APB_DATA_WD
);

  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [ADDR_WD-1:0] paddr;
  logic [DATA_WD-1:0] pwdata;
  logic               pready;
  logic [DATA_WD-1:0] prdata;
  logic               pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_WD storage: one synchronous write port, one combinational
// read port. Reads of unimplemented addresses return zero.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int DATA_WD = APB_DATA_WD,
  parameter int ADDR_WD = APB_ADDR_WD,
  parameter int DEPTH   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [ADDR_WD-1:0] waddr,
  input  logic [DATA_WD-1:0] wdata,
  input  logic [ADDR_WD-1:0] raddr,
  output logic [DATA_WD-1:0] rdata
);

  localparam logic [ADDR_WD:0] DEPTH_EXT = (ADDR_WD + 1)'(DEPTH);

  logic [DATA_WD-1:0] mem [DEPTH];

  // Storage array; reset clears every word, writers guarantee waddr < DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read with out-of-range guard.
  always_comb begin
    rdata = '0;
    if ({1'b0, raddr} < DEPTH_EXT) begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer holding a small register array. Each transfer is stretched
// by WAIT_CYCLES wait states; addresses at or above DEPTH answer with
// PSLVERR and leave storage untouched. All bus outputs are registered.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int DATA_WD     = APB_DATA_WD,
  parameter int ADDR_WD     = APB_ADDR_WD,
  parameter int DEPTH       = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  apb_slave_mem_if.slave       bus
);

  localparam logic [ADDR_WD:0]    DEPTH_EXT = (ADDR_WD + 1)'(DEPTH);
  localparam logic [CNT_WD-1:0]   WAIT_CNT  = CNT_WD'(WAIT_CYCLES);

  // Unsigned compare one bit wider so DEPTH = 2^ADDR_WD never flags.
  function automatic logic is_oob(input logic [ADDR_WD-1:0] a);
    return ({1'b0, a} >= DEPTH_EXT);
  endfunction

  apb_state_e         state_q, state_d;
  logic [CNT_WD-1:0]  cnt_q, cnt_d;
  logic               write_q, write_d;
  logic               err_q, err_d;
  logic [ADDR_WD-1:0] addr_q, addr_d;
  logic [DATA_WD-1:0] wdata_q, wdata_d;
  logic               pready_q, pready_d;
  logic               pslverr_q, pslverr_d;
  logic [DATA_WD-1:0] prdata_q, prdata_d;

  logic               we;
  logic [ADDR_WD-1:0] rd_addr;
  logic [DATA_WD-1:0] rd_data;
  logic               access;

  assign access = bus.psel & bus.penable;

  apb_slave_regfile #(
    .DATA_WD (DATA_WD),
    .ADDR_WD (ADDR_WD),
    .DEPTH   (DEPTH)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Next-state, latch and response logic. Outputs default to the idle
  // response so pready/pslverr/prdata are high/valid only on entry to DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    we        = 1'b0;
    rd_addr   = addr_q;

    case (state_q)
      IDLE: begin
        // Zero-wait reads must fetch from the live address on the setup edge.
        rd_addr = bus.paddr;
        if (bus.psel && !bus.penable) begin
          addr_d  = bus.paddr;
          write_d = bus.pwrite;
          wdata_d = bus.pwdata;
          err_d   = is_oob(bus.paddr);
          cnt_d   = WAIT_CNT;
          if (WAIT_CYCLES == 0) begin
            state_d   = DONE;
            pready_d  = 1'b1;
            pslverr_d = is_oob(bus.paddr);
            prdata_d  = (!bus.pwrite && !is_oob(bus.paddr)) ? rd_data : '0;
          end else begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (!bus.psel) begin
          state_d = IDLE;
        end else if (bus.penable) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_WD'(1)) begin
            state_d   = DONE;
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = (!write_q && !err_q) ? rd_data : '0;
          end
        end
      end

      DONE: begin
        // Commit only if the master actually completes the access phase.
        we      = access && write_q && !err_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and registered bus responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Latched address and write data; only meaningful once a setup is seen.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: three instances with 0, 1 and 3 wait
// states share clock and reset. The driver pushes expected responses from a
// plain array model; a negedge monitor pops and compares on every pready.
module tb_apb_slave_mem;

  localparam int NDUT = 3;
  localparam int DEP  = 12;

  typedef struct {
    logic [3:0] rdata;
    logic       err;
    int         start;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  logic       psel_d    [NDUT];
  logic       penable_d [NDUT];
  logic       pwrite_d  [NDUT];
  logic [3:0] paddr_d   [NDUT];
  logic [3:0] pwdata_d  [NDUT];
  logic       pready_o  [NDUT];
  logic [3:0] prdata_o  [NDUT];
  logic       pslverr_o [NDUT];

  int wc [NDUT] = '{0, 1, 3};

  logic [3:0] mm [NDUT][16];
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    apb_slave_mem_if #(.ADDR_WD(4), .DATA_WD(4)) bus ();
    assign bus.psel    = psel_d[g];
    assign bus.penable = penable_d[g];
    assign bus.pwrite  = pwrite_d[g];
    assign bus.paddr   = paddr_d[g];
    assign bus.pwdata  = pwdata_d[g];
    assign pready_o[g]  = bus.pready;
    assign prdata_o[g]  = bus.prdata;
    assign pslverr_o[g] = bus.pslverr;
    apb_slave_mem #(
      .DATA_WD     (4),
      .ADDR_WD     (4),
      .DEPTH       (DEP),
      .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon_one(input int d);
    exp_t e;
    bit   have;
    have = 1'b0;
    case (d)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_pready dut%0d: got pready=1 expected no response (t=%0t)", d, $time);
    end else begin
      chk("prdata", d, 32'(prdata_o[d]), 32'(e.rdata));
      chk("pslverr", d, 32'(pslverr_o[d]), 32'(e.err));
      chk("latency", d, 32'(cyc - e.start), 32'(wc[d] + 1));
    end
  endtask

  // Monitor: every cycle with pready high must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < NDUT; d++) begin
        if (pready_o[d]) mon_one(d);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int d = 0; d < NDUT; d++) begin
      psel_d[d]    = 1'b0;
      penable_d[d] = 1'b0;
    end
    repeat (n) step();
  endtask

  task automatic clear_model();
    for (int d = 0; d < NDUT; d++)
      for (int a = 0; a < 16; a++) mm[d][a] = 4'h0;
  endtask

  // One complete transfer; returns at the start of the cycle after pready,
  // leaving psel/penable high so a following call is back-to-back.
  task automatic xfer(input int d, input bit wr, input logic [3:0] a, input logic [3:0] v);
    exp_t e;
    bit   got;
    e.err   = (int'(a) >= DEP);
    e.rdata = (!wr && !e.err) ? mm[d][a] : 4'h0;
    e.start = cyc;
    if (wr && !e.err) mm[d][a] = v;
    push(d, e);
    psel_d[d]    = 1'b1;
    penable_d[d] = 1'b0;
    pwrite_d[d]  = wr;
    paddr_d[d]   = a;
    pwdata_d[d]  = v;
    step();
    penable_d[d] = 1'b1;
    pwrite_d[d]  = 1'($urandom);
    paddr_d[d]   = 4'($urandom);
    pwdata_d[d]  = 4'($urandom);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (pready_o[d]) got = 1'b1;
      else step();
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout dut%0d: got no pready expected pready within 40 cycles", d);
    end
    step();
  endtask

  initial begin
    int prev;
    for (int d = 0; d < NDUT; d++) begin
      psel_d[d] = 1'b0; penable_d[d] = 1'b0; pwrite_d[d] = 1'b0;
      paddr_d[d] = 4'h0; pwdata_d[d] = 4'h0;
    end
    clear_model();

    // Reset state
    repeat (3) step();
    for (int d = 0; d < NDUT; d++) begin
      chk("rst_pready", d, 32'(pready_o[d]), 32'h0);
      chk("rst_prdata", d, 32'(prdata_o[d]), 32'h0);
      chk("rst_pslverr", d, 32'(pslverr_o[d]), 32'h0);
    end
    rst_n = 1'b1;
    idle(2);

    // One wait state: write then read back, then psel/penable held in IDLE
    xfer(1, 1'b1, 4'd3, 4'hA);
    xfer(1, 1'b0, 4'd3, 4'h0);
    repeat (3) step();
    idle(1);

    // Zero wait: sweep write and read back
    for (int a = 0; a < DEP; a++) xfer(0, 1'b1, 4'(a), 4'(a));
    for (int a = 0; a < DEP; a++) xfer(0, 1'b0, 4'(a), 4'h0);
    idle(1);

    // Out-of-range addresses and boundary
    xfer(1, 1'b1, 4'd13, 4'h5);
    xfer(1, 1'b0, 4'd13, 4'h0);
    xfer(1, 1'b0, 4'd1, 4'h0);
    xfer(1, 1'b1, 4'd12, 4'h6);
    xfer(1, 1'b1, 4'd11, 4'h9);
    xfer(1, 1'b0, 4'd11, 4'h0);
    xfer(1, 1'b0, 4'd15, 4'h0);
    idle(1);

    // Abort during WAIT on the three-wait instance
    psel_d[2] = 1'b1; penable_d[2] = 1'b0; pwrite_d[2] = 1'b1;
    paddr_d[2] = 4'd2; pwdata_d[2] = 4'hF;
    step();
    penable_d[2] = 1'b1;
    step();
    idle(5);
    xfer(2, 1'b0, 4'd2, 4'h0);
    idle(1);

    // Randomized traffic
    prev = 0;
    for (int i = 0; i < 200; i++) begin
      int d;
      d = int'($urandom_range(0, NDUT - 1));
      if (d != prev) idle(0);
      if ($urandom_range(0, 3) == 0) idle(1);
      xfer(d, 1'($urandom), 4'($urandom_range(0, 15)), 4'($urandom));
      prev = d;
    end
    idle(2);

    // Reset while pready is high on a read of a nonzero word
    xfer(1, 1'b1, 4'd3, 4'hA);
    idle(0);
    push(1, '{rdata: 4'hA, err: 1'b0, start: cyc});
    psel_d[1] = 1'b1; penable_d[1] = 1'b0; pwrite_d[1] = 1'b0; paddr_d[1] = 4'd3;
    step();
    penable_d[1] = 1'b1;
    step();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pready", 1, 32'(pready_o[1]), 32'h0);
    chk("rst_mid_prdata", 1, 32'(prdata_o[1]), 32'h0);
    chk("rst_mid_pslverr", 1, 32'(pslverr_o[1]), 32'h0);
    clear_model();
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Reset during WAIT of a write; the write must be lost
    psel_d[2] = 1'b1; penable_d[2] = 1'b0; pwrite_d[2] = 1'b1;
    paddr_d[2] = 4'd5; pwdata_d[2] = 4'h7;
    step();
    penable_d[2] = 1'b1;
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_wait_pready", 2, 32'(pready_o[2]), 32'h0);
    chk("rst_wait_prdata", 2, 32'(prdata_o[2]), 32'h0);
    clear_model();
    idle(2);
    rst_n = 1'b1;
    idle(1);
    for (int d = 0; d < NDUT; d++) begin
      for (int a = 0; a < DEP; a++) xfer(d, 1'b0, 4'(a), 4'h0);
      idle(0);
    end
    idle(3);

    chk("q0_drained", 0, 32'(q0.size()), 32'h0);
    chk("q1_drained", 1, 32'(q1.size()), 32'h0);
    chk("q2_drained", 2, 32'(q2.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute guard against a stalled run.
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1);
  end

endmodule
